alu_seq: RTL and testbench

- Parametrised, registered ALU that succeeds the team's combinational 32-bit ALU for the pipelined/multi-cycle datapath.
- Keeps the existing 4-bit function encoding and adds:
  - right shifts and signed set-less-than;
  - an iterative shift-add multiplier;
  - status flags and an illegal-opcode error.
- Operands enter through a valid/ready handshake. Results leave through a registered valid/ready output stage.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle operations load the result registers on the accept edge.
// MUL runs an iterative shift-add that takes WIDTH cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (func, op_a, op_b)
//   out_valid / out_ready result handshake (alu_res, flag_z/n/c/v, err)
//
// State table:
//   IDLE | accepting operations; single-cycle results are produced here
//   MUL  | shift-add multiply in progress; input side is stalled
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_SUB  = 4'b0100;
  localparam logic [3:0] F_OR   = 4'b1000;
  localparam logic [3:0] F_NOT  = 4'b1010;
  localparam logic [3:0] F_XOR  = 4'b1100;
  localparam logic [3:0] F_SLL  = 4'b1110;
  localparam logic [3:0] F_PASS = 4'b0001;
  localparam logic [3:0] F_SRL  = 4'b0011;
  localparam logic [3:0] F_SRA  = 4'b0101;
  localparam logic [3:0] F_SLT  = 4'b0111;
  localparam logic [3:0] F_MUL  = 4'b1001;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic             accept, mul_start, mul_last;

  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c, err_c;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (func == F_MUL);
  assign mul_last  = (state == MUL) && (cnt == CNT_LAST);

  // One shift-add step; the final step's sum is what gets published.
  assign acc_step = mplier[0] ? acc + mcand : acc;

  assign sh    = op_b[SHW-1:0];
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    err_c = 1'b0;
    case (func)
      F_AND:  res_c = op_a & op_b;
      F_ADD: begin
        res_c = add_w[WIDTH-1:0];
        c_c   = add_w[WIDTH];
        v_c   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                (add_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      F_SUB: begin
        res_c = sub_w[WIDTH-1:0];
        c_c   = sub_w[WIDTH];
        v_c   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                (sub_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      F_OR:   res_c = op_a | op_b;
      F_NOT:  res_c = ~op_a;
      F_XOR:  res_c = op_a ^ op_b;
      F_SLL:  res_c = op_a << sh;
      F_PASS: res_c = op_a;
      F_SRL:  res_c = op_a >> sh;
      F_SRA:  res_c = $unsigned($signed(op_a) >>> sh);
      F_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F_MUL:  res_c = '0;
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mul_start) state_nxt = MUL;
      MUL:  if (mul_last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (mul_start) begin
      cnt    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
    end else if (state == MUL) begin
      cnt    <= cnt + SHW'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_step;
    end
  end

  // Output stage. An illegal func yields res_c==0, so flag_z comes out 1
  // and every other flag 0 without a separate path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_res   <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else if (mul_last) begin
      out_valid <= 1'b1;
      alu_res   <= acc_step;
      flag_z    <= (acc_step == '0);
      flag_n    <= acc_step[WIDTH-1];
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      alu_res   <= res_c;
      flag_z    <= (res_c == '0);
      flag_n    <= res_c[WIDTH-1];
      flag_c    <= c_c;
      flag_v    <= v_c;
      err       <= err_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq at WIDTH=32.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_alu_seq;
  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       func = 4'b0000;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] alu_res;
  logic             flag_z, flag_n, flag_c, flag_v, err;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_res(alu_res),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, let it be accepted on the next edge and check the
  // registered result. in_valid is left high so calls chain at 1 op/cycle.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input logic [3:0] exp_znc, input logic exp_err);
    in_valid = 1'b1;
    func = f;
    op_a = a;
    op_b = b;
    tick();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, alu_res, exp_res);
    check({tag, "_flags"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, exp_znc});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    int  cyc;
    logic ready_low;
    logic saw_valid;

    // Reset state
    repeat (2) tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res", alu_res, 32'd0);
    check("rst_flags", {27'd0, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // ADD / SUB with flags, back-to-back
    do_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b0101, 1'b0);
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b1010, 1'b0);
    do_op("sub_neg",  4'b0100, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0100, 1'b0);
    do_op("sub_pos",  4'b0100, 32'd7, 32'd5, 32'd2,         4'b0010, 1'b0);
    do_op("sub_ovf",  4'b0100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, 1'b0);

    // Shifts, SLT, logic ops
    do_op("sra",      4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0100, 1'b0);
    do_op("srl",      4'b0011, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'b0000, 1'b0);
    do_op("sll_mask", 4'b1110, 32'd1, 32'h21, 32'd2, 4'b0000, 1'b0);
    do_op("srl_by32", 4'b0011, 32'h1234_5678, 32'h20, 32'h1234_5678, 4'b0000, 1'b0);
    do_op("slt_true", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1'b0);
    do_op("slt_false",4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'b1000, 1'b0);
    do_op("or",       4'b1000, 32'hF0, 32'h0F, 32'hFF, 4'b0000, 1'b0);
    do_op("xor",      4'b1100, 32'hFF, 32'h0F, 32'hF0, 4'b0000, 1'b0);
    do_op("not",      4'b1010, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    do_op("pass",     4'b0001, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 4'b0100, 1'b0);

    // Illegal codes and recovery
    do_op("ill_0110", 4'b0110, 32'h1234, 32'h5678, 32'h0, 4'b1000, 1'b1);
    do_op("and_clr",  4'b0000, 32'hF0, 32'h3C, 32'h30, 4'b0000, 1'b0);
    do_op("ill_1111", 4'b1111, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b1000, 1'b1);
    do_op("and_clr2", 4'b0000, 32'hF0, 32'h3C, 32'h30, 4'b0000, 1'b0);

    // Release without new accept: out_valid drops, result holds
    in_valid = 1'b0;
    tick();
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_hold", alu_res, 32'h30);

    // MUL 7 x 6: latency WIDTH, in_ready low throughout
    in_valid = 1'b1; func = 4'b1001; op_a = 32'd7; op_b = 32'd6;
    tick();
    in_valid = 1'b0;
    cyc = 0; ready_low = 1'b1;
    while (!out_valid && cyc < 40) begin
      if (in_ready) ready_low = 1'b0;
      tick();
      cyc++;
    end
    check("mul1_lat", cyc, 32'd32);
    check("mul1_ready_low", {31'd0, ready_low}, 32'd1);
    check("mul1_res", alu_res, 32'd42);
    check("mul1_flags", {27'd0, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);

    // MUL 0xFFFFFFFF^2 with in_valid held high (ADD 1+1) during the multiply;
    // the ADD must only be taken after the product is published.
    tick();
    in_valid = 1'b1; func = 4'b1001; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    tick();
    func = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("mul2_lat", cyc, 32'd32);
    check("mul2_res", alu_res, 32'd1);
    check("mul2_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("after_mul_add", alu_res, 32'd2);
    check("after_mul_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Reset during MUL: abandoned, no stale result afterwards
    in_valid = 1'b1; func = 4'b1001; op_a = 32'd7; op_b = 32'd6;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_res", alu_res, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    check("mrst_no_stale", {31'd0, saw_valid}, 32'd0);

    // Back-pressure: result held, next op not accepted until out_ready
    out_ready = 1'b0;
    do_op("bp_xor", 4'b1100, 32'h55, 32'h0F, 32'h5A, 4'b0000, 1'b0);
    func = 4'b0000; op_a = 32'hFF; op_b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res", alu_res, 32'h5A);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_take_valid", {31'd0, out_valid}, 32'd1);
    check("bp_take_res", alu_res, 32'h0F);
    do_op("stream1", 4'b0010, 32'd10, 32'd20, 32'd30, 4'b0000, 1'b0);
    do_op("stream2", 4'b0100, 32'd3,  32'd3,  32'd0,  4'b1010, 1'b0);
    do_op("stream3", 4'b1000, 32'h100, 32'h1, 32'h101, 4'b0000, 1'b0);
    in_valid = 1'b0;
    tick();
    check("stream_end", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
